pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_pkg.sv | 18 +
 rtl/ce_div.sv | 41 ++++
 rtl/pll_reset_seq.sv | 161 ++++++++++++++++
 tb/tb_pll_reset_seq.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/pll_reset_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
package pll_reset_pkg;

    localparam int DEF_LOCK_STABLE_CYCLES = 1024;
    localparam int DEF_STAGE_GAP          = 16;
    localparam int DEF_CE_VDC_DIV         = 4;
    localparam int DEF_CE_CPU_DIV         = 6;
    localparam int LOSS_CNT_W             = 8;

    typedef enum logic [2:0] {
        WAIT_LOCK  = 3'd0,
        STABLE     = 3'd1,
        REL_PERIPH = 3'd2,
        REL_CORE   = 3'd3,
        RUN        = 3'd4
    } pll_state_e;

endpackage

// File: rtl/ce_div.sv
// Clock-enable divider: emits a one-cycle pulse every DIV cycles while run=1.
// The counter is held at zero outside run so every RUN entry starts phase-aligned.
module ce_div #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    output logic ce
);

    localparam int              CW   = $clog2(DIV + 1);
    localparam logic [CW-1:0]   LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: hold zero outside run, wrap at DIV-1 inside run.
    always_comb begin
        cnt_d = cnt_q;
        if (!run) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Counter register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign ce = run && (cnt_q == LAST);

endmodule

// File: rtl/pll_reset_seq.sv
// PLL lock-qualified staged reset release with clock-enable generation.
// Optional lock-loss counter output enabled by defining PLL_RESET_LOSS_CNT_EN.
//
//   state      | meaning
//   WAIT_LOCK  | waiting for synchronized lock
//   STABLE     | counting consecutive lock cycles
//   REL_PERIPH | peripherals out of reset, core held
//   REL_CORE   | core out of reset, waiting final gap
//   RUN        | everything released, enables running
module pll_reset_seq
    import pll_reset_pkg::*;
#(
    parameter int LOCK_STABLE_CYCLES = DEF_LOCK_STABLE_CYCLES,
    parameter int STAGE_GAP          = DEF_STAGE_GAP,
    parameter int CE_VDC_DIV         = DEF_CE_VDC_DIV,
    parameter int CE_CPU_DIV         = DEF_CE_CPU_DIV
) (
    input  logic clk,
    input  logic rst,
    input  logic pll_locked,
    output logic periph_rst,
    output logic core_rst,
    output logic ce_vdc,
    output logic ce_cpu,
    output logic ready
`ifdef PLL_RESET_LOSS_CNT_EN
    ,
    output logic [LOSS_CNT_W-1:0] lock_loss_cnt
`endif
);

    localparam int                STABLE_W  = $clog2(LOCK_STABLE_CYCLES + 1);
    localparam int                GAP_W     = $clog2(STAGE_GAP + 1);
    localparam logic [STABLE_W-1:0] STABLE_TC = STABLE_W'(LOCK_STABLE_CYCLES);
    localparam logic [GAP_W-1:0]    GAP_TC    = GAP_W'(STAGE_GAP);

    pll_state_e          state_q, state_d;
    logic [STABLE_W-1:0] stable_cnt_q, stable_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic                lock_meta_q, lock_meta_d;
    logic                lock_s_q, lock_s_d;
    logic [STABLE_W-1:0] stable_inc;
    logic [GAP_W-1:0]    gap_inc;
    logic                run;

    assign stable_inc = stable_cnt_q + STABLE_W'(1);
    assign gap_inc    = gap_cnt_q + GAP_W'(1);

    // Next-state and stage counters; loss of lock overrides every transition.
    always_comb begin
        state_d      = state_q;
        stable_cnt_d = stable_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        lock_meta_d  = pll_locked;
        lock_s_d     = lock_meta_q;
        case (state_q)
            WAIT_LOCK: begin
                stable_cnt_d = '0;
                gap_cnt_d    = '0;
                if (lock_s_q) begin
                    state_d = STABLE;
                end
            end
            STABLE: begin
                if (stable_inc == STABLE_TC) begin
                    state_d   = REL_PERIPH;
                    gap_cnt_d = '0;
                end else begin
                    stable_cnt_d = stable_inc;
                end
            end
            REL_PERIPH: begin
                if (gap_inc == GAP_TC) begin
                    state_d   = REL_CORE;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_inc;
                end
            end
            REL_CORE: begin
                if (gap_inc == GAP_TC) begin
                    state_d   = RUN;
                    gap_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_inc;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
        if ((state_q != WAIT_LOCK) && !lock_s_q) begin
            state_d      = WAIT_LOCK;
            stable_cnt_d = '0;
            gap_cnt_d    = '0;
        end
    end

    // State, counters and lock synchronizer registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WAIT_LOCK;
            stable_cnt_q <= '0;
            gap_cnt_q    <= '0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            stable_cnt_q <= stable_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            lock_meta_q  <= lock_meta_d;
            lock_s_q     <= lock_s_d;
        end
    end

`ifdef PLL_RESET_LOSS_CNT_EN
    logic [LOSS_CNT_W-1:0] loss_cnt_q, loss_cnt_d;

    // Count lock drops that knock the sequencer out of RUN, saturating.
    always_comb begin
        loss_cnt_d = loss_cnt_q;
        if ((state_q == RUN) && !lock_s_q && (loss_cnt_q != '1)) begin
            loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
        end
    end

    // Loss counter register; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            loss_cnt_q <= '0;
        end else begin
            loss_cnt_q <= loss_cnt_d;
        end
    end

    assign lock_loss_cnt = loss_cnt_q;
`endif

    assign run        = (state_q == RUN);
    assign ready      = run;
    assign periph_rst = !((state_q == REL_PERIPH) || (state_q == REL_CORE) || (state_q == RUN));
    assign core_rst   = !((state_q == REL_CORE) || (state_q == RUN));

    ce_div #(.DIV(CE_VDC_DIV)) u_ce_vdc (
        .clk (clk),
        .rst (rst),
        .run (run),
        .ce  (ce_vdc)
    );

    ce_div #(.DIV(CE_CPU_DIV)) u_ce_cpu (
        .clk (clk),
        .rst (rst),
        .run (run),
        .ce  (ce_cpu)
    );

endmodule

// File: tb/tb_pll_reset_seq.sv
// Self-checking bench for pll_reset_seq. Reference model tracks only the
// number of consecutive edges at which the sequencer has seen lock, and
// derives every output arithmetically from that run length.
module tb_pll_reset_seq;

    localparam int LSC    = 8;
    localparam int GAP    = 4;
    localparam int VDIV   = 4;
    localparam int CDIV   = 6;
    localparam int RUN_K  = LSC + 2 * GAP + 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pll_locked = 1'b0;
    logic periph_rst, core_rst, ce_vdc, ce_cpu, ready;
`ifdef PLL_RESET_LOSS_CNT_EN
    logic [7:0] lock_loss_cnt;
`endif

    pll_reset_seq #(
        .LOCK_STABLE_CYCLES (LSC),
        .STAGE_GAP          (GAP),
        .CE_VDC_DIV         (VDIV),
        .CE_CPU_DIV         (CDIV)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .pll_locked    (pll_locked),
        .periph_rst    (periph_rst),
        .core_rst      (core_rst),
        .ce_vdc        (ce_vdc),
        .ce_cpu        (ce_cpu),
        .ready         (ready)
`ifdef PLL_RESET_LOSS_CNT_EN
        ,
        .lock_loss_cnt (lock_loss_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // model: m_k = consecutive lock-high edges seen by the sequencer
    int m_k    = 0;
    bit m_s1   = 1'b0;
    bit m_s2   = 1'b0;
    int m_loss = 0;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit rdy;
        int idx;
        bit ev, ec;
        rdy = (m_k >= RUN_K);
        idx = m_k - RUN_K;
        ev  = rdy && ((idx % VDIV) == VDIV - 1);
        ec  = rdy && ((idx % CDIV) == CDIV - 1);
        chk("periph_rst", 8'(periph_rst), 8'(m_k <= LSC));
        chk("core_rst",   8'(core_rst),   8'(m_k <= LSC + GAP));
        chk("ready",      8'(ready),      8'(rdy));
        chk("ce_vdc",     8'(ce_vdc),     8'(ev));
        chk("ce_cpu",     8'(ce_cpu),     8'(ec));
`ifdef PLL_RESET_LOSS_CNT_EN
        chk("lock_loss_cnt", lock_loss_cnt, 8'(m_loss));
`endif
    endtask

    task automatic step(input logic r, input logic l);
        @(negedge clk);
        rst        = r;
        pll_locked = l;
        @(posedge clk);
        if (r) begin
            m_s1 = 1'b0; m_s2 = 1'b0; m_k = 0; m_loss = 0;
        end else begin
            if (m_s2) begin
                if (m_k < 1000000) m_k++;
            end else begin
                if (m_k >= RUN_K && m_loss < 255) m_loss++;
                m_k = 0;
            end
            m_s2 = m_s1;
            m_s1 = l;
        end
        #1 check_outputs();
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    initial begin
        int first_pr, first_cr, first_rdy;
        int n_v, n_c;
        int hi, lo;

        // reset state
        do_reset();
        chk("rst_periph", 8'(periph_rst), 8'd1);
        chk("rst_core",   8'(core_rst),   8'd1);
        chk("rst_ready",  8'(ready),      8'd0);

        // nominal release timing and enable pattern over 24 RUN cycles
        first_pr = -1; first_cr = -1; first_rdy = -1; n_v = 0; n_c = 0;
        for (int e = 0; e < 45; e++) begin
            step(1'b0, 1'b1);
            if (first_pr  < 0 && periph_rst === 1'b0) first_pr  = e;
            if (first_cr  < 0 && core_rst   === 1'b0) first_cr  = e;
            if (first_rdy < 0 && ready      === 1'b1) first_rdy = e;
            if (e >= 18 && e < 42) begin
                if (ce_vdc === 1'b1) n_v++;
                if (ce_cpu === 1'b1) n_c++;
            end
        end
        chk("edge_periph_rel", 8'(first_pr),  8'd10);
        chk("edge_core_rel",   8'(first_cr),  8'd14);
        chk("edge_ready",      8'(first_rdy), 8'd18);
        chk("vdc_pulses_24",   8'(n_v),       8'd6);
        chk("cpu_pulses_24",   8'(n_c),       8'd4);

        // lock drop in RUN: resets back three edges later
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        chk("drop_ready_hold", 8'(ready), 8'd1);
        step(1'b0, 1'b0);
        chk("drop_periph", 8'(periph_rst), 8'd1);
        chk("drop_core",   8'(core_rst),   8'd1);
        chk("drop_ready",  8'(ready),      8'd0);
        chk("drop_ce",     8'({ce_vdc, ce_cpu}), 8'd0);
`ifdef PLL_RESET_LOSS_CNT_EN
        chk("drop_loss", lock_loss_cnt, 8'd1);
`endif

        // one-cycle lock glitch while STABLE count is 5
        do_reset();
        first_pr = -1;
        for (int e = 0; e < 30; e++) begin
            step(1'b0, (e == 6) ? 1'b0 : 1'b1);
            if (first_pr < 0 && periph_rst === 1'b0) first_pr = e;
        end
        chk("glitch_periph_rel", 8'(first_pr), 8'd17);

        // rst pulse while in REL_CORE restarts from WAIT_LOCK
        do_reset();
        for (int e = 0; e < 15; e++) step(1'b0, 1'b1);
        chk("pre_rst_core", 8'(core_rst), 8'd0);
        step(1'b1, 1'b1);
        chk("rstpulse_periph", 8'(periph_rst), 8'd1);
        chk("rstpulse_core",   8'(core_rst),   8'd1);
        chk("rstpulse_ready",  8'(ready),      8'd0);
        first_pr = -1;
        for (int e = 0; e < 25; e++) begin
            step(1'b0, 1'b1);
            if (first_pr < 0 && periph_rst === 1'b0) first_pr = e;
        end
        chk("rstpulse_periph_rel", 8'(first_pr), 8'd10);

        // randomized lock behaviour with occasional resets
        do_reset();
        for (int s = 0; s < 40; s++) begin
            hi = int'($urandom_range(3, 40));
            lo = int'($urandom_range(1, 3));
            for (int i = 0; i < hi; i++) step(1'b0, 1'b1);
            for (int i = 0; i < lo; i++) step(1'b0, 1'b0);
            if ($urandom_range(0, 7) == 0) step(1'b1, 1'(($urandom_range(0, 1))));
        end

`ifdef PLL_RESET_LOSS_CNT_EN
        // saturation of the lock-loss counter
        do_reset();
        for (int s = 0; s < 300; s++) begin
            for (int i = 0; i < 22; i++) step(1'b0, 1'b1);
            for (int i = 0; i < 3; i++)  step(1'b0, 1'b0);
        end
        chk("loss_saturate", lock_loss_cnt, 8'd255);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
